imm_extend_unit: RTL and testbench
==================================

# imm_extend_unit

Parametrised, registered immediate-generation stage for the MIPS datapath. Widens an IN_W-bit instruction immediate to OUT_W bits under a per-transaction mode: sign-extend, zero-extend, sign-extend with shift-left-1 for branch offsets, or upper-load placement. A PREFIX mode lets a preceding instruction supply the upper PFX_W bits of the next immediate. The block sits between decode and the ALU operand mux with a valid/ready handshake on both sides, and gives one cycle of latency at full throughput.

## Interface
- IN_W, default 7: input immediate width; must satisfy 1 ≤ IN_W < OUT_W.
- OUT_W, default 16: output operand width.
- PFX_W (localparam): OUT_W − IN_W, the prefix payload width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush, e.g. on branch mispredict.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  3  extension mode (imm_mode_t).
- in_pfx  in  PFX_W  prefix payload; sampled only in PREFIX mode.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  OUT_W  extended immediate.
- out_pfx_used  out  1  result was built from a stored prefix.
- out_err  out  1  input mode was reserved.

## Operation
Modes:
- 0 SEXT: {PFX_W{in_imm[IN_W−1]}, in_imm}.
- 1 ZEXT: {PFX_W'0, in_imm}.
- 2 SEXT_SHL1: SEXT result shifted left by 1, truncated to OUT_W, LSB = 0.
- 3 LUI: in_imm placed at the top, {in_imm, PFX_W'0}.
- 4 PREFIX: loads pfx_reg ← in_pfx. Emits no output.
- 5–7 reserved: computed as SEXT, with out_err = 1.

Accept and output rules:
- An input is accepted when in_valid && in_ready.
- in_ready = rst_n && !flush && (!out_valid || out_ready).

Prefix FSM:
- States: IDLE and ARMED.
- IDLE + accepted PREFIX → ARMED; pfx_reg loaded.
- ARMED + accepted PREFIX → ARMED; pfx_reg reloaded; still no output.
- ARMED + accepted non-PREFIX op (any mode, including reserved) → out_imm = {pfx_reg, in_imm}, out_pfx_used = 1, state → IDLE. The mode bits are ignored, but out_err still reflects a reserved mode.
- In IDLE, every non-PREFIX op produces a result per the mode table, with out_pfx_used = 0.

Output register:
- Any accepted non-PREFIX op loads out_imm, out_pfx_used and out_err, and sets out_valid.
- Otherwise, out_valid clears when out_ready is high.
- While out_valid && !out_ready, all outputs hold stable.

Flush:
- At the next edge: out_valid ← 0, state ← IDLE, pfx_reg ← 0.
- Any input presented in the same cycle is not accepted, because in_ready = 0.

## Timing
- Reset (async assert, sync-safe deassert): out_valid = 0, out_imm = 0, out_pfx_used = 0, out_err = 0, state = IDLE, pfx_reg = 0. in_ready = 0 while rst_n is low.
- Latency: a non-PREFIX op accepted at edge N is visible on out_* after edge N. PREFIX ops consume one accept slot and produce no output.
- Throughput: one accept per cycle while out_ready stays high. Simultaneous output drain and new accept in the same cycle is required.
- Reset asserted mid-transaction: the pending result and any armed prefix are discarded.
- Flush and out_ready high together: flush wins; nothing is accepted and out_valid = 0 next cycle.

## Structure
- Package imm_pkg holds:
  - imm_mode_t, a 3-bit enum: SEXT, ZEXT, SEXT_SHL1, LUI, PREFIX, plus reserved codes.
  - The prefix state typedef, pfx_state_t: IDLE, ARMED.
- One natural sub-module: imm_extend_comb, a pure combinational mode-to-value function parameterised by IN_W and OUT_W. The top level holds the FSM, pfx_reg and the output register.

## Test plan
Test plan values use IN_W=7, OUT_W=16, with out_ready held high unless noted.
- SEXT 7'h40 → 16'hFFC0 one cycle after accept. Then ZEXT 7'h40 → 16'h0040, with out_err = 0 and out_pfx_used = 0 on both.
- SEXT_SHL1 7'h7F → 16'hFFFE. LUI 7'h05 → 16'h0A00. Mode 3'd6 with 7'h7F → 16'hFFFF, out_err = 1.
- PREFIX in_pfx = 9'h1A5, then ZEXT 7'h7F → 16'hD2FF with out_pfx_used = 1. The following SEXT 7'h01 → 16'h0001 with out_pfx_used = 0.
- Backpressure:
  - Drive out_ready = 0 for 3 cycles with two back-to-back ops.
  - The first result holds stable and in_ready = 0.
  - The cycle out_ready rises, the second op is accepted and its result appears on the next cycle.
  - Every op is seen exactly once; none is lost or duplicated.
- Flush while ARMED and out_valid = 1, with a SEXT presented the same cycle: out_valid = 0 next cycle and that op is not accepted. A later SEXT 7'h7F → 16'hFFFF with out_pfx_used = 0.
- Assert rst_n = 0 mid-cycle while ARMED with out_valid = 1: all outputs go to 0 immediately and in_ready = 0. After release, ZEXT 7'h01 → 16'h0001, with no prefix applied.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension stage: mode encoding and prefix FSM states.
package imm_pkg;

    // Extension mode carried with every transaction; codes 5-7 are reserved.
    typedef enum logic [2:0] {
        MODE_SEXT      = 3'd0,
        MODE_ZEXT      = 3'd1,
        MODE_SEXT_SHL1 = 3'd2,
        MODE_LUI       = 3'd3,
        MODE_PREFIX    = 3'd4,
        MODE_RSVD5     = 3'd5,
        MODE_RSVD6     = 3'd6,
        MODE_RSVD7     = 3'd7
    } imm_mode_t;

    // Prefix tracking: ARMED means the next non-prefix op takes its upper bits from pfx_reg.
    typedef enum logic {
        PFX_IDLE  = 1'b0,
        PFX_ARMED = 1'b1
    } pfx_state_t;

    // True for the reserved mode codes, which are computed as SEXT but flagged.
    function automatic logic mode_is_reserved(input imm_mode_t mode);
        logic rsvd;
        case (mode)
            MODE_SEXT, MODE_ZEXT, MODE_SEXT_SHL1, MODE_LUI, MODE_PREFIX: rsvd = 1'b0;
            default:                                                     rsvd = 1'b1;
        endcase
        return rsvd;
    endfunction

endpackage

// File: rtl/imm_extend_comb.sv
// Pure combinational widening of an immediate according to its mode, with
// optional substitution of a stored prefix for the upper bits.
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]       imm,
    input  imm_mode_t             mode,
    input  logic                  pfx_armed,
    input  logic [OUT_W-IN_W-1:0] pfx,
    output logic [OUT_W-1:0]      value,
    output logic                  err
);

    localparam int PFX_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] mode_val_s;

    assign sext_s = {{PFX_W{imm[IN_W-1]}}, imm};

    // Select the mode-table result; reserved codes fall back to sign extension.
    always_comb begin
        mode_val_s = sext_s;
        case (mode)
            MODE_SEXT:      mode_val_s = sext_s;
            MODE_ZEXT:      mode_val_s = {{PFX_W{1'b0}}, imm};
            MODE_SEXT_SHL1: mode_val_s = {sext_s[OUT_W-2:0], 1'b0};
            MODE_LUI:       mode_val_s = {imm, {PFX_W{1'b0}}};
            MODE_PREFIX:    mode_val_s = sext_s;
            default:        mode_val_s = sext_s;
        endcase
    end

    // An armed prefix overrides the mode bits entirely; the error flag still tracks the mode.
    assign value = pfx_armed ? {pfx, imm} : mode_val_s;
    assign err   = mode_is_reserved(mode);

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate-generation stage: prefix FSM, prefix register and
// output register with valid/ready handshakes on both sides.
module imm_extend_unit
    import imm_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [2:0]            in_mode,
    input  logic [OUT_W-IN_W-1:0] in_pfx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_imm,
    output logic                  out_pfx_used,
    output logic                  out_err
);

    localparam int PFX_W = OUT_W - IN_W;

    pfx_state_t       state_r;
    logic [PFX_W-1:0] pfx_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_imm_r;
    logic             out_pfx_used_r;
    logic             out_err_r;

    imm_mode_t        mode_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             is_prefix_s;
    logic             armed_s;
    logic [OUT_W-1:0] value_s;
    logic             err_s;

    assign mode_s      = imm_mode_t'(in_mode);
    assign in_ready_s  = rst_n && !flush && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign is_prefix_s = (mode_s == MODE_PREFIX);
    assign armed_s     = (state_r == PFX_ARMED);

    imm_extend_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .imm       (in_imm),
        .mode      (mode_s),
        .pfx_armed (armed_s),
        .pfx       (pfx_r),
        .value     (value_s),
        .err       (err_s)
    );

    // Prefix FSM and output register; flush discards pending work and any armed prefix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= PFX_IDLE;
            pfx_r          <= {PFX_W{1'b0}};
            out_valid_r    <= 1'b0;
            out_imm_r      <= {OUT_W{1'b0}};
            out_pfx_used_r <= 1'b0;
            out_err_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= PFX_IDLE;
            pfx_r       <= {PFX_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (accept_s && is_prefix_s) begin
            // Accept implies the output register is empty or draining this cycle.
            state_r     <= PFX_ARMED;
            pfx_r       <= in_pfx;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            state_r        <= PFX_IDLE;
            out_valid_r    <= 1'b1;
            out_imm_r      <= value_s;
            out_pfx_used_r <= armed_s;
            out_err_r      <= err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_imm      = out_imm_r;
    assign out_pfx_used = out_pfx_used_r;
    assign out_err      = out_err_r;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: directed stimulus pushes expected
// results, a monitor pops and compares on every output handshake.
module tb_imm_extend_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_imm;
    logic [2:0]  in_mode;
    logic [8:0]  in_pfx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic        out_pfx_used;
    logic        out_err;

    typedef struct {
        logic [15:0] imm;
        logic        used;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   total;
    int   bad;
    int   n_push;
    int   n_xfer;

    imm_extend_unit #(.IN_W(7), .OUT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mode      (in_mode),
        .in_pfx       (in_pfx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_pfx_used (out_pfx_used),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one op (caller is just after a rising edge); wait for acceptance.
    task automatic send(input logic [2:0] mode, input logic [6:0] imm, input logic [8:0] pfx,
                        input logic [15:0] eimm, input logic eused, input logic eerr,
                        input logic produce);
        exp_t e;
        bit   ok;
        in_valid = 1'b1;
        in_mode  = mode;
        in_imm   = imm;
        in_pfx   = pfx;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else if (produce) begin
            e.imm  = eimm;
            e.used = eused;
            e.err  = eerr;
            q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per completed output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
                n_xfer++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h expected none", out_imm);
                end else begin
                    mon_e = q.pop_front();
                    check("out_imm", 32'(out_imm), 32'(mon_e.imm));
                    check("out_pfx_used", 32'(out_pfx_used), 32'(mon_e.used));
                    check("out_err", 32'(out_err), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; n_push = 0; n_xfer = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = 7'h00; in_mode = 3'd0; in_pfx = 9'h000;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", 32'(out_imm), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Mode table
        send(3'd0, 7'h40, 9'h000, 16'hFFC0, 1'b0, 1'b0, 1'b1);
        send(3'd1, 7'h40, 9'h000, 16'h0040, 1'b0, 1'b0, 1'b1);
        send(3'd2, 7'h7F, 9'h000, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(3'd3, 7'h05, 9'h000, 16'h0A00, 1'b0, 1'b0, 1'b1);
        send(3'd6, 7'h7F, 9'h000, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        // Prefix use then plain op
        send(3'd4, 7'h00, 9'h1A5, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(3'd1, 7'h7F, 9'h000, 16'hD2FF, 1'b1, 1'b0, 1'b1);
        send(3'd0, 7'h01, 9'h000, 16'h0001, 1'b0, 1'b0, 1'b1);
        // Prefix reload, consumed by a reserved mode
        send(3'd4, 7'h00, 9'h0F0, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(3'd4, 7'h00, 9'h003, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(3'd5, 7'h11, 9'h000, 16'h0191, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Backpressure: first result holds, second op waits
        out_ready = 1'b0;
        send(3'd1, 7'h2A, 9'h000, 16'h002A, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in_mode = 3'd0; in_imm = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_imm", 32'(out_imm), 32'h002A);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tmp_e.imm = 16'hFFD5; tmp_e.used = 1'b0; tmp_e.err = 1'b0;
        q.push_back(tmp_e);
        n_push++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);

        // Flush with a pending result and a same-cycle op
        out_ready = 1'b0;
        send(3'd0, 7'h10, 9'h000, 16'h0010, 1'b0, 1'b0, 1'b1);
        flush = 1'b1; in_valid = 1'b1; in_mode = 3'd0; in_imm = 7'h22;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        tmp_e = q.pop_front();
        n_push--;
        out_ready = 1'b1;
        // Flush while armed drops the prefix
        send(3'd4, 7'h00, 9'h1FF, 16'h0000, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        send(3'd0, 7'h7F, 9'h000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Async reset with a pending result
        out_ready = 1'b0;
        send(3'd1, 7'h33, 9'h000, 16'h0033, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_imm", 32'(out_imm), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        tmp_e = q.pop_front();
        n_push--;
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        // Async reset while armed drops the prefix
        send(3'd4, 7'h00, 9'h155, 16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst2_in_ready", 32'(in_ready), 32'd0);
        idle(1);
        rst_n = 1'b1;
        send(3'd1, 7'h01, 9'h000, 16'h0001, 1'b0, 1'b0, 1'b1);
        idle(3);

        check("sb_empty", 32'(q.size()), 32'd0);
        check("xfer_count", 32'(n_xfer), 32'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
